// File: rtl/dmem_arbiter_if.sv
// Signal bundle shared by the data-memory arbiter, the CPU load/store stage,
// the VPU and the single data-memory port.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // CPU load/store stage
    logic              cpu_re;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    // VPU burst port
    logic              vpu_req;
    logic              vpu_we;
    logic [ADDR_W-1:0] vpu_addr;
    logic [3:0]        vpu_len;
    logic [DATA_W-1:0] vpu_wdata;
    logic              vpu_gnt;
    logic              vpu_beat;
    logic [DATA_W-1:0] vpu_rdata;
    logic              vpu_rvalid;
    logic              vpu_done;

    // Memory port
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  vpu_req, vpu_we, vpu_addr, vpu_len, vpu_wdata,
        output vpu_gnt, vpu_beat, vpu_rdata, vpu_rvalid, vpu_done,
        output mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory side
    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output vpu_req, vpu_we, vpu_addr, vpu_len, vpu_wdata,
        input  vpu_gnt, vpu_beat, vpu_rdata, vpu_rvalid, vpu_done,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU gets single-beat priority access, the VPU gets
// incrementing bursts of up to 8 beats with a starvation guard. Read data is
// steered back to its owner through a MEM_LAT-deep tag pipeline.
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int              SC_W       = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    logic [1:0]         state_q, state_d;
    logic [SC_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [3:0]         rem_q, rem_d;
    logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [MEM_LAT-1:0] tag_vpu_q, tag_vpu_d;
    logic [MEM_LAT-1:0] tag_last_q, tag_last_d;

    logic              cpu_acc;
    logic              vpu_win;
    logic [3:0]        len_eff;
    logic              cpu_issue;
    logic              vpu_issue;
    logic              vpu_last;
    logic              vpu_wdone;
    logic              gnt;
    logic              stall;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic              mem_re_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              ret_vld;
    logic              ret_vpu;
    logic              ret_last;
    logic              cpu_rv;
    logic              vpu_rv;

    assign cpu_acc = bus.cpu_re | bus.cpu_we;
    assign vpu_win = bus.vpu_req & (~cpu_acc | (starve_cnt_q == STARVE_MAX));

    // Burst length: 0 behaves as a single beat, anything above 8 is clamped
    always_comb begin
        len_eff = bus.vpu_len;
        if (bus.vpu_len == 4'd0) begin
            len_eff = 4'd1;
        end else if (bus.vpu_len > 4'd8) begin
            len_eff = 4'd8;
        end
    end

    // Arbitration FSM: decides who owns the memory port this cycle
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        rem_d     = rem_q;
        cpu_issue = 1'b0;
        vpu_issue = 1'b0;
        vpu_last  = 1'b0;
        vpu_wdone = 1'b0;
        gnt       = 1'b0;
        stall     = 1'b0;
        cur_we    = we_q;
        cur_addr  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (vpu_win) begin
                    gnt       = 1'b1;
                    vpu_issue = 1'b1;
                    stall     = cpu_acc;
                    cur_we    = bus.vpu_we;
                    cur_addr  = bus.vpu_addr;
                    addr_d    = bus.vpu_addr + ADDR_W'(1);
                    we_d      = bus.vpu_we;
                    rem_d     = len_eff - 4'd1;
                    if (len_eff == 4'd1) begin
                        vpu_last  = 1'b1;
                        vpu_wdone = bus.vpu_we;
                        state_d   = bus.vpu_we ? ST_IDLE : ST_DRAIN;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else begin
                    cpu_issue = cpu_acc;
                end
            end
            ST_BURST: begin
                vpu_issue = 1'b1;
                stall     = cpu_acc;
                addr_d    = addr_q + ADDR_W'(1);
                rem_d     = rem_q - 4'd1;
                if (rem_q == 4'd1) begin
                    vpu_last  = 1'b1;
                    vpu_wdone = we_q;
                    state_d   = we_q ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Port is free while the last read beats are in flight
                cpu_issue = cpu_acc;
                if (ret_vld && ret_vpu && ret_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory port drive for whichever requester issues this cycle
    always_comb begin
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (vpu_issue) begin
            mem_we_o   = cur_we;
            mem_re_o   = ~cur_we;
            mem_addr_o = cur_addr;
            if (cur_we) begin
                mem_wdata_o = bus.vpu_wdata;
            end
        end else if (cpu_issue) begin
            // Simultaneous re/we is a store
            mem_we_o   = bus.cpu_we;
            mem_re_o   = bus.cpu_re & ~bus.cpu_we;
            mem_addr_o = bus.cpu_addr;
            if (bus.cpu_we) begin
                mem_wdata_o = bus.cpu_wdata;
            end
        end
    end

    // Starvation counter: counts denied VPU request cycles, cleared on grant
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt) begin
            starve_cnt_d = '0;
        end else if (bus.vpu_req && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        end
    end

    // Read-owner tag pipeline, one stage per cycle of memory latency
    always_comb begin
        tag_vld_d     = tag_vld_q;
        tag_vpu_d     = tag_vpu_q;
        tag_last_d    = tag_last_q;
        tag_vld_d[0]  = mem_re_o;
        tag_vpu_d[0]  = vpu_issue;
        tag_last_d[0] = vpu_last;
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_vpu_d[i]  = tag_vpu_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
        end
    end

    // Control state with synchronous reset; abandons any burst in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            tag_vld_q    <= '0;
            tag_vpu_q    <= '0;
            tag_last_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            tag_vld_q    <= tag_vld_d;
            tag_vpu_q    <= tag_vpu_d;
            tag_last_q   <= tag_last_d;
        end
    end

    // Burst bookkeeping; only meaningful while state_q says a burst is live
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        we_q   <= we_d;
        rem_q  <= rem_d;
    end

    assign ret_vld  = tag_vld_q[MEM_LAT-1];
    assign ret_vpu  = tag_vpu_q[MEM_LAT-1];
    assign ret_last = tag_last_q[MEM_LAT-1];
    assign cpu_rv   = ~rst & ret_vld & ~ret_vpu;
    assign vpu_rv   = ~rst & ret_vld & ret_vpu;

    assign bus.cpu_stall  = ~rst & stall;
    assign bus.cpu_rvalid = cpu_rv;
    assign bus.cpu_rdata  = cpu_rv ? bus.mem_rdata : '0;
    assign bus.vpu_gnt    = ~rst & gnt;
    assign bus.vpu_beat   = ~rst & vpu_issue;
    assign bus.vpu_rvalid = vpu_rv;
    assign bus.vpu_rdata  = vpu_rv ? bus.mem_rdata : '0;
    assign bus.vpu_done   = ~rst & (vpu_wdone | (vpu_rv & ret_last));
    assign bus.mem_re     = ~rst & mem_re_o;
    assign bus.mem_we     = ~rst & mem_we_o;
    assign bus.mem_addr   = rst ? '0 : mem_addr_o;
    assign bus.mem_wdata  = rst ? '0 : mem_wdata_o;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table against a MEM_LAT=2
// instance, plus hand sequences against a MEM_LAT=1 instance.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_LIMIT(3)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_LIMIT(3)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    localparam logic        N   = 1'b0;
    localparam logic        Y   = 1'b1;
    localparam logic [15:0] Z16 = 16'h0000;

    // Memory contents: 0x0040 holds 0xBEEF, everything else a fixed pattern
    function automatic logic [15:0] mv(input logic [15:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        return a ^ 16'h5A5A;
    endfunction

    logic [15:0] m1_q;
    logic [15:0] m2_q [2];
    always @(posedge clk) begin
        m1_q    <= bus1.mem_re ? mv(bus1.mem_addr) : 16'hDEAD;
        m2_q[0] <= bus2.mem_re ? mv(bus2.mem_addr) : 16'hDEAD;
        m2_q[1] <= m2_q[0];
    end
    assign bus1.mem_rdata = m1_q;
    assign bus2.mem_rdata = m2_q[1];

    typedef struct packed {
        logic        cre, cwe;
        logic [15:0] caddr, cwd;
        logic        vreq, vwe;
        logic [15:0] vaddr;
        logic [3:0]  vlen;
        logic [15:0] vwd;
    } in_t;

    typedef struct packed {
        logic        stall, crv;
        logic [15:0] crd;
        logic        gnt, beat, vrv;
        logic [15:0] vrd;
        logic        done, mre, mwe;
        logic [15:0] maddr, mwd;
    } exp_t;

    typedef struct {
        string name;
        logic  rst;
        in_t   i;
        exp_t  e;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic in_t fi(input logic cre, cwe, input logic [15:0] caddr, cwd,
                               input logic vreq, vwe, input logic [15:0] vaddr,
                               input logic [3:0] vlen, input logic [15:0] vwd);
        in_t v;
        v.cre = cre; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.vreq = vreq; v.vwe = vwe; v.vaddr = vaddr; v.vlen = vlen; v.vwd = vwd;
        return v;
    endfunction

    function automatic exp_t fe(input logic stall, crv, input logic [15:0] crd,
                                input logic gnt, beat, vrv, input logic [15:0] vrd,
                                input logic done, mre, mwe, input logic [15:0] maddr, mwd);
        exp_t v;
        v.stall = stall; v.crv = crv; v.crd = crd; v.gnt = gnt; v.beat = beat;
        v.vrv = vrv; v.vrd = vrd; v.done = done; v.mre = mre; v.mwe = mwe;
        v.maddr = maddr; v.mwd = mwd;
        return v;
    endfunction

    task automatic add(input string nm, input logic r, input in_t i, input exp_t e);
        vec_t v;
        v.name = nm; v.rst = r; v.i = i; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t v);
        bus1.cpu_re = v.cre; bus1.cpu_we = v.cwe; bus1.cpu_addr = v.caddr; bus1.cpu_wdata = v.cwd;
        bus1.vpu_req = v.vreq; bus1.vpu_we = v.vwe; bus1.vpu_addr = v.vaddr;
        bus1.vpu_len = v.vlen; bus1.vpu_wdata = v.vwd;
        bus2.cpu_re = v.cre; bus2.cpu_we = v.cwe; bus2.cpu_addr = v.caddr; bus2.cpu_wdata = v.cwd;
        bus2.vpu_req = v.vreq; bus2.vpu_we = v.vwe; bus2.vpu_addr = v.vaddr;
        bus2.vpu_len = v.vlen; bus2.vpu_wdata = v.vwd;
    endtask

    function automatic exp_t act2();
        exp_t a;
        a.stall = bus2.cpu_stall; a.crv = bus2.cpu_rvalid; a.crd = bus2.cpu_rdata;
        a.gnt = bus2.vpu_gnt; a.beat = bus2.vpu_beat; a.vrv = bus2.vpu_rvalid;
        a.vrd = bus2.vpu_rdata; a.done = bus2.vpu_done; a.mre = bus2.mem_re;
        a.mwe = bus2.mem_we; a.maddr = bus2.mem_addr; a.mwd = bus2.mem_wdata;
        return a;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    initial begin
        in_t  i0;
        exp_t z;
        exp_t a;
        i0 = fi(N, N, Z16, Z16, N, N, Z16, 4'd0, Z16);
        z  = fe(N, N, Z16, N, N, N, Z16, N, N, N, Z16, Z16);

        // Reset state
        add("rst_busy", Y, fi(Y, N, 16'h0040, Z16, Y, N, 16'h0100, 4'd4, Z16), z);
        add("rst_idle", Y, i0, z);
        add("post_rst", N, i0, z);
        // CPU load, load+store (treated as store), store
        add("cpu_ld",   N, fi(Y, N, 16'h0040, Z16, N, N, Z16, 4'd0, Z16), fe(N, N, Z16, N, N, N, Z16, N, Y, N, 16'h0040, Z16));
        add("cpu_rw",   N, fi(Y, Y, 16'h0050, 16'h2222, N, N, Z16, 4'd0, Z16), fe(N, N, Z16, N, N, N, Z16, N, N, Y, 16'h0050, 16'h2222));
        add("cpu_st",   N, fi(N, Y, 16'h0123, 16'h1111, N, N, Z16, 4'd0, Z16), fe(N, Y, 16'hBEEF, N, N, N, Z16, N, N, Y, 16'h0123, 16'h1111));
        add("cpu_norv", N, i0, z);
        add("cpu_idle", N, i0, z);
        // VPU write burst len=4 at 0x0100, CPU stalled during it
        add("vw_b0",    N, fi(N, N, Z16, Z16, Y, Y, 16'h0100, 4'd4, 16'hA000), fe(N, N, Z16, Y, Y, N, Z16, N, N, Y, 16'h0100, 16'hA000));
        add("vw_b1",    N, fi(Y, N, 16'h0040, Z16, N, N, Z16, 4'd0, 16'hA001), fe(Y, N, Z16, N, Y, N, Z16, N, N, Y, 16'h0101, 16'hA001));
        add("vw_b2",    N, fi(Y, N, 16'h0040, Z16, N, N, Z16, 4'd0, 16'hA002), fe(Y, N, Z16, N, Y, N, Z16, N, N, Y, 16'h0102, 16'hA002));
        add("vw_b3",    N, fi(Y, N, 16'h0040, Z16, N, N, Z16, 4'd0, 16'hA003), fe(Y, N, Z16, N, Y, N, Z16, Y, N, Y, 16'h0103, 16'hA003));
        add("vw_cpu",   N, fi(Y, N, 16'h0040, Z16, N, N, Z16, 4'd0, Z16), fe(N, N, Z16, N, N, N, Z16, N, Y, N, 16'h0040, Z16));
        add("vw_idle",  N, i0, z);
        add("vw_cpurv", N, i0, fe(N, Y, 16'hBEEF, N, N, N, Z16, N, N, N, Z16, Z16));
        // VPU read burst len=3 at 0xFFFE, address wraps
        add("vr_b0",    N, fi(N, N, Z16, Z16, Y, N, 16'hFFFE, 4'd3, Z16), fe(N, N, Z16, Y, Y, N, Z16, N, Y, N, 16'hFFFE, Z16));
        add("vr_b1",    N, i0, fe(N, N, Z16, N, Y, N, Z16, N, Y, N, 16'hFFFF, Z16));
        add("vr_b2",    N, i0, fe(N, N, Z16, N, Y, Y, mv(16'hFFFE), N, Y, N, 16'h0000, Z16));
        add("vr_d0",    N, i0, fe(N, N, Z16, N, N, Y, mv(16'hFFFF), N, N, N, Z16, Z16));
        add("vr_d1",    N, i0, fe(N, N, Z16, N, N, Y, mv(16'h0000), Y, N, N, Z16, Z16));
        add("vr_idle",  N, i0, z);
        // Length 0 behaves as 1; length 15 clamps to 8
        add("len0",     N, fi(N, N, Z16, Z16, Y, Y, 16'h0200, 4'd0, 16'h7777), fe(N, N, Z16, Y, Y, N, Z16, Y, N, Y, 16'h0200, 16'h7777));
        add("len0_end", N, i0, z);
        for (int b = 0; b < 8; b++) begin
            add($sformatf("len15_b%0d", b), N,
                (b == 0) ? fi(N, N, Z16, Z16, Y, Y, 16'h0210, 4'd15, 16'h7777)
                         : fi(N, N, Z16, Z16, N, N, Z16, 4'd0, 16'h7777),
                fe(N, N, Z16, (b == 0), Y, N, Z16, (b == 7), N, Y, 16'(16'h0210 + b), 16'h7777));
        end
        add("len15_end", N, fi(N, N, Z16, Z16, N, N, Z16, 4'd0, 16'h7777), z);
        // Len-1 read, then a request held through DRAIN is granted after vpu_done
        add("r1_b0",    N, fi(N, N, Z16, Z16, Y, N, 16'h0300, 4'd1, Z16), fe(N, N, Z16, Y, Y, N, Z16, N, Y, N, 16'h0300, Z16));
        add("r1_drain", N, fi(N, N, Z16, Z16, Y, Y, 16'h0310, 4'd1, 16'h5555), z);
        add("r1_done",  N, fi(N, N, Z16, Z16, Y, Y, 16'h0310, 4'd1, 16'h5555), fe(N, N, Z16, N, N, Y, mv(16'h0300), Y, N, N, Z16, Z16));
        add("r1_regnt", N, fi(N, N, Z16, Z16, Y, Y, 16'h0310, 4'd1, 16'h5555), fe(N, N, Z16, Y, Y, N, Z16, Y, N, Y, 16'h0310, 16'h5555));
        add("r1_idle",  N, i0, z);
        // Starvation: CPU loads every cycle, VPU wins on the 4th cycle
        add("sv_c0", N, fi(Y, N, 16'h0010, Z16, Y, Y, 16'h0400, 4'd2, 16'h3333), fe(N, N, Z16, N, N, N, Z16, N, Y, N, 16'h0010, Z16));
        add("sv_c1", N, fi(Y, N, 16'h0011, Z16, Y, Y, 16'h0400, 4'd2, 16'h3333), fe(N, N, Z16, N, N, N, Z16, N, Y, N, 16'h0011, Z16));
        add("sv_c2", N, fi(Y, N, 16'h0012, Z16, Y, Y, 16'h0400, 4'd2, 16'h3333), fe(N, Y, mv(16'h0010), N, N, N, Z16, N, Y, N, 16'h0012, Z16));
        add("sv_c3", N, fi(Y, N, 16'h0013, Z16, Y, Y, 16'h0400, 4'd2, 16'h3333), fe(Y, Y, mv(16'h0011), Y, Y, N, Z16, N, N, Y, 16'h0400, 16'h3333));
        add("sv_c4", N, fi(Y, N, 16'h0013, Z16, N, N, Z16, 4'd0, 16'h3333), fe(Y, Y, mv(16'h0012), N, Y, N, Z16, Y, N, Y, 16'h0401, 16'h3333));
        add("sv_c5", N, fi(Y, N, 16'h0013, Z16, N, N, Z16, 4'd0, Z16), fe(N, N, Z16, N, N, N, Z16, N, Y, N, 16'h0013, Z16));
        add("sv_c6", N, i0, z);
        add("sv_c7", N, i0, fe(N, Y, mv(16'h0013), N, N, N, Z16, N, N, N, Z16, Z16));
        // CPU reads before and during DRAIN interleaved with VPU returns
        add("dr_p0", N, fi(Y, N, 16'h0060, Z16, Y, N, 16'h0500, 4'd2, Z16), fe(N, N, Z16, N, N, N, Z16, N, Y, N, 16'h0060, Z16));
        add("dr_p1", N, fi(N, N, Z16, Z16, Y, N, 16'h0500, 4'd2, Z16), fe(N, N, Z16, Y, Y, N, Z16, N, Y, N, 16'h0500, Z16));
        add("dr_p2", N, fi(Y, N, 16'h0040, Z16, N, N, Z16, 4'd0, Z16), fe(Y, Y, mv(16'h0060), N, Y, N, Z16, N, Y, N, 16'h0501, Z16));
        add("dr_p3", N, fi(Y, N, 16'h0040, Z16, N, N, Z16, 4'd0, Z16), fe(N, N, Z16, N, N, Y, mv(16'h0500), N, Y, N, 16'h0040, Z16));
        add("dr_p4", N, i0, fe(N, N, Z16, N, N, Y, mv(16'h0501), Y, N, N, Z16, Z16));
        add("dr_p5", N, i0, fe(N, Y, 16'hBEEF, N, N, N, Z16, N, N, N, Z16, Z16));
        add("dr_p6", N, i0, z);
        // Reset during beat 2 of a len-8 read abandons the burst
        add("rb_b0",   N, fi(N, N, Z16, Z16, Y, N, 16'h0600, 4'd8, Z16), fe(N, N, Z16, Y, Y, N, Z16, N, Y, N, 16'h0600, Z16));
        add("rb_b1",   N, i0, fe(N, N, Z16, N, Y, N, Z16, N, Y, N, 16'h0601, Z16));
        add("rb_rst",  Y, i0, z);
        add("rb_c1",   N, i0, z);
        add("rb_c2",   N, i0, z);
        add("rb_c3",   N, i0, z);
        add("rb_ld",   N, fi(Y, N, 16'h0040, Z16, N, N, Z16, 4'd0, Z16), fe(N, N, Z16, N, N, N, Z16, N, Y, N, 16'h0040, Z16));
        add("rb_idle", N, i0, z);
        add("rb_rv",   N, i0, fe(N, Y, 16'hBEEF, N, N, N, Z16, N, N, N, Z16, Z16));

        rst = 1'b1;
        drive(i0);
        @(posedge clk);
        @(posedge clk);
        #1;

        // Table against the MEM_LAT=2 instance
        foreach (tbl[k]) begin
            rst = tbl[k].rst;
            drive(tbl[k].i);
            @(negedge clk);
            a = act2();
            checks++;
            if (a !== tbl[k].e) begin
                failures++;
                $display("FAIL %s actual=%h required=%h", tbl[k].name, a, tbl[k].e);
            end
            @(posedge clk);
            #1;
        end

        // MEM_LAT=1 instance: CPU load of 0x0040
        rst = 1'b1;
        drive(i0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(fi(Y, N, 16'h0040, Z16, N, N, Z16, 4'd0, Z16));
        @(negedge clk);
        chk("l1_ld_re",    16'(bus1.mem_re), 16'h0001);
        chk("l1_ld_addr",  bus1.mem_addr, 16'h0040);
        chk("l1_ld_stall", 16'(bus1.cpu_stall), 16'h0000);
        chk("l1_ld_rv0",   16'(bus1.cpu_rvalid), 16'h0000);
        @(posedge clk);
        #1;
        drive(i0);
        @(negedge clk);
        chk("l1_ld_rv1",   16'(bus1.cpu_rvalid), 16'h0001);
        chk("l1_ld_data",  bus1.cpu_rdata, 16'hBEEF);
        chk("l1_ld_stall1", 16'(bus1.cpu_stall), 16'h0000);
        @(posedge clk);
        #1;

        // MEM_LAT=1 instance: read burst len=3 at 0xFFFE
        for (int c = 0; c < 6; c++) begin
            drive((c == 0) ? fi(N, N, Z16, Z16, Y, N, 16'hFFFE, 4'd3, Z16) : i0);
            @(negedge clk);
            chk($sformatf("l1_rd_re_c%0d", c), 16'(bus1.mem_re), 16'(c < 3));
            if (c < 3) chk($sformatf("l1_rd_addr_c%0d", c), bus1.mem_addr, 16'(16'hFFFE + c));
            chk($sformatf("l1_rd_rv_c%0d", c), 16'(bus1.vpu_rvalid), 16'((c >= 1) && (c <= 3)));
            if ((c >= 1) && (c <= 3))
                chk($sformatf("l1_rd_data_c%0d", c), bus1.vpu_rdata, mv(16'(16'hFFFE + c - 1)));
            chk($sformatf("l1_rd_done_c%0d", c), 16'(bus1.vpu_done), 16'(c == 3));
            chk($sformatf("l1_rd_crv_c%0d", c), 16'(bus1.cpu_rvalid), 16'h0000);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
